// File: rtl/data_mem_unit.sv
// Load/store responder on a single-port sync-read word RAM; optional word-crossing split (MISALIGN_SPLIT_EN).
// Latency: resp at T+2 (aligned), T+3 (split), T+1 (illegal mode / misaligned without split support).
// Backpressure: req_ready_o only in IDLE; one request in flight, the core stalls otherwise.
module data_mem_unit #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_mode_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    mode_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_q;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_idx;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdat;

    logic          accept, illegal_in, misalign_in, err_in;
    logic [3:0]    size_mask;
    logic [7:0]    be_w;
    logic [63:0]   wdat_w, rd_w, sh_w;
    logic [31:0]   load_res;

    assign accept     = req_valid_i && req_ready_o;
    // BU/HU exist only as loads; 011 and 11x are never legal
    assign illegal_in = (req_mode_i == 3'b011) || (req_mode_i[2:1] == 2'b11)
                     || (req_mode_i[2] && req_write_i);

`ifdef MISALIGN_SPLIT_EN
    logic        split;
    logic [31:0] lo_q;
    assign misalign_in = 1'b0;
    // Only H at offset 3 and W at a nonzero offset spill into the next word
    assign split = ((mode_q[1:0] == 2'b01) && (off_q == 2'd3))
                || ((mode_q[1:0] == 2'b10) && (off_q != 2'd0));
`else
    assign misalign_in = ((req_mode_i[1:0] == 2'b01) && req_addr_i[0])
                      || ((req_mode_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`endif
    assign err_in = illegal_in || misalign_in;

    // Byte lanes and store data positioned across a two-word window starting at the offset
    assign size_mask = (mode_q[1:0] == 2'b00) ? 4'b0001 :
                       (mode_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign be_w      = {4'b0000, size_mask} << off_q;
    assign wdat_w    = {32'h0, wdata_q} << {off_q, 3'b000};

    // State register and request capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            off_q   <= '0;
            idx_q   <= '0;
            mode_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q   <= req_addr_i[1:0];
                idx_q   <= req_addr_i[AW+1:2];
                mode_q  <= req_mode_i;
                write_q <= req_write_i;
                wdata_q <= req_wdata_i;
                err_q   <= err_in;
            end
            if (state_q == RESP) begin
                rdata_q <= load_res;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_i) state_d = err_in ? RESP : ACC0;
`ifdef MISALIGN_SPLIT_EN
            ACC0: state_d = split ? ACC1 : RESP;
            ACC1: state_d = RESP;
`else
            ACC0: state_d = RESP;
`endif
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and RAM port controls
    always_comb begin
        req_ready_o  = (state_q == IDLE) && !rst_i;
        resp_valid_o = (state_q == RESP);
        resp_err_o   = (state_q == RESP) && err_q;
        ram_en       = (state_q == ACC0);
        ram_idx      = idx_q;
        ram_be       = be_w[3:0];
        ram_wdat     = wdat_w[31:0];
`ifdef MISALIGN_SPLIT_EN
        if (state_q == ACC1) begin
            ram_en   = 1'b1;
            ram_idx  = idx_q + 1'b1;
            ram_be   = be_w[7:4];
            ram_wdat = wdat_w[63:32];
        end
`endif
        ram_we = ram_en && write_q;
    end

    // Word RAM: synchronous read, per-byte write enables
    always_ff @(posedge clk_i) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we && ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdat[8*b +: 8];
            end
            ram_q <= mem[ram_idx];
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Keep the first word of a split load while the second is read
    always_ff @(posedge clk_i) begin
        if (state_q == ACC1) lo_q <= ram_q;
    end
    assign rd_w = split ? {ram_q, lo_q} : {32'h0, ram_q};
`else
    assign rd_w = {32'h0, ram_q};
`endif

    // Little-endian byte assembly and sign/zero extension
    always_comb begin
        sh_w = rd_w >> {off_q, 3'b000};
        case (mode_q[1:0])
            2'b00:   load_res = {{24{!mode_q[2] && sh_w[7]}},  sh_w[7:0]};
            2'b01:   load_res = {{16{!mode_q[2] && sh_w[15]}}, sh_w[15:0]};
            default: load_res = sh_w[31:0];
        endcase
        if (write_q || err_q) load_res = '0;
    end

    assign resp_rdata_o = (state_q == RESP) ? load_res : rdata_q;

    logic unused_ok;
    assign unused_ok = ^{req_addr_i[31:AW+2], sh_w[63:32], be_w[7:4], wdat_w[63:32]};

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_mode = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int passed = 0;
    int total  = 0;

    data_mem_unit #(.DEPTH(DEPTH), .AW(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_mode_i   (req_mode),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request and wait for its response; lat counts cycles after acceptance
    task automatic do_req(input logic w, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_write = w; req_mode = m; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom_range(0, 1);
        req_mode = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata; er = resp_err;
    endtask

    task automatic ld(input string tag, input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_lat);
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, m, a, 32'h0, rd, er, lat);
        chk({tag, ".data"}, rd, exp);
        chk({tag, ".err"}, 32'(er), 32'd0);
        chk({tag, ".lat"}, lat, exp_lat);
    endtask

    task automatic st(input string tag, input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat);
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, m, a, d, rd, er, lat);
        chk({tag, ".data"}, rd, 32'h0);
        chk({tag, ".err"}, 32'(er), 32'd0);
        chk({tag, ".lat"}, lat, exp_lat);
    endtask

    task automatic bad(input string tag, input logic w, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic er; int lat;
        do_req(w, m, a, d, rd, er, lat);
        chk({tag, ".data"}, rd, 32'h0);
        chk({tag, ".err"}, 32'(er), 32'd1);
        chk({tag, ".lat"}, lat, 1);
    endtask

    initial begin
        logic [31:0] w10;
        int seen;

        // Reset state
        #12;
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.rdata", resp_rdata, 32'h0);
        chk("rst.err", 32'(resp_err), 32'd0);
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("rel.ready", 32'(req_ready), 32'd1);

        // Word store/load and byte merge
        st("sw10", 3'b010, 32'h10, 32'hDEADBEEF, 2);
        ld("lw10", 3'b010, 32'h10, 32'hDEADBEEF, 2);
        st("sb13", 3'b000, 32'h13, 32'h00000080, 2);
        ld("lb13", 3'b000, 32'h13, 32'hFFFFFF80, 2);
        ld("lbu13", 3'b100, 32'h13, 32'h00000080, 2);
        ld("lw10b", 3'b010, 32'h10, 32'h80ADBEEF, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("hold.valid", 32'(resp_valid), 32'd0);
        chk("hold.rdata", resp_rdata, 32'h80ADBEEF);
        ld("lh10", 3'b001, 32'h10, 32'hFFFFBEEF, 2);
        ld("lhu12", 3'b101, 32'h12, 32'h000080AD, 2);
        ld("lb11", 3'b000, 32'h11, 32'hFFFFFFBE, 2);
        st("sh0e_pre", 3'b010, 32'h0C, 32'hAABBCCDD, 2);
        st("sh0c", 3'b001, 32'h0C, 32'h00007E01, 2);
        ld("lw0c", 3'b010, 32'h0C, 32'hAABB7E01, 2);
        st("sw0c", 3'b010, 32'h0C, 32'hAABBCCDD, 2);

        // Illegal modes leave RAM untouched
        bad("ill011", 1'b0, 3'b011, 32'h10, 32'h0);
        bad("ill011w", 1'b1, 3'b011, 32'h10, 32'h12345678);
        bad("illsbu", 1'b1, 3'b100, 32'h10, 32'h00000055);
        bad("ill110", 1'b1, 3'b110, 32'h10, 32'h00000055);
        ld("lw10c", 3'b010, 32'h10, 32'h80ADBEEF, 2);
        w10 = 32'h80ADBEEF;

`ifdef MISALIGN_SPLIT_EN
        // Split accesses across a word boundary
        st("sw0e", 3'b010, 32'h0E, 32'h11223344, 3);
        ld("lw0c_s", 3'b010, 32'h0C, 32'h3344CCDD, 2);
        ld("lh10_s", 3'b001, 32'h10, 32'h00001122, 2);
        ld("lw0e_s", 3'b010, 32'h0E, 32'h11223344, 3);
        w10 = 32'h80AD1122;
        st("sbtop", 3'b000, DEPTH*4-1, 32'h00000034, 2);
        st("sb0", 3'b000, 32'h0, 32'h00000012, 2);
        ld("lhwrap", 3'b001, DEPTH*4-1, 32'h00001234, 3);
        ld("lhuwrap", 3'b101, DEPTH*4-1, 32'h00001234, 3);
`else
        // Misaligned requests are rejected without touching RAM
        bad("mis_lw02", 1'b0, 3'b010, 32'h02, 32'h0);
        bad("mis_lh11", 1'b0, 3'b001, 32'h11, 32'h0);
        bad("mis_sw0e", 1'b1, 3'b010, 32'h0E, 32'h11223344);
        ld("lw0c_u", 3'b010, 32'h0C, 32'hAABBCCDD, 2);
        ld("lw10_u", 3'b010, 32'h10, 32'h80ADBEEF, 2);
`endif
        // Upper address bits are ignored
        ld("lwhigh", 3'b010, 32'h0001_0010, w10, 2);

        // Reset in the middle of a store
        st("sw20", 3'b010, 32'h20, 32'h0, 2);
        st("sw24", 3'b010, 32'h24, 32'h0, 2);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_mode = 3'b010;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h22; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
`else
        req_addr = 32'h20; req_wdata = 32'h55555555;
        @(posedge clk); #1;
        req_valid = 1'b0;
`endif
        rst = 1'b1; #1;
        chk("mid.ready", 32'(req_ready), 32'd0);
        chk("mid.valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("mid.relready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("mid.nopulse", seen, 0);
`ifdef MISALIGN_SPLIT_EN
        ld("mid.w20", 3'b010, 32'h20, 32'hF00D0000, 2);
`else
        ld("mid.w20", 3'b010, 32'h20, 32'h00000000, 2);
`endif
        ld("mid.w24", 3'b010, 32'h24, 32'h00000000, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
